// File: rtl/fifo_wr_scheduler_if.sv
// ============================================================================
// Module   : fifo_wr_scheduler_if
// Purpose  : Producer-side request/data bundle plus FIFO write-port signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wr_scheduler_if #(
  parameter int MEMORY_WIDTH = 4,
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_SIZE = 2
);
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*MEMORY_WIDTH-1:0] req_data;
  logic                            full;
  logic [NUM_REQ-1:0]              gnt;
  logic                            w_en;
  logic [MEMORY_WIDTH-1:0]         wdata;
  logic [REQ_IDX_SIZE-1:0]         owner;
  logic                            busy;

  // The scheduler is the master of the FIFO write port.
  modport master (
    input  req, req_data, full,
    output gnt, w_en, wdata, owner, busy
  );

  modport slave (
    output req, req_data, full,
    input  gnt, w_en, wdata, owner, busy
  );
endinterface

`default_nettype wire

// File: rtl/fifo_wr_scheduler.sv
// ============================================================================
// Module   : fifo_wr_scheduler
// Purpose  : Round-robin, burst-bounded sharing of one FIFO write port.
//            Optional macro FIFO_SCHED_PRIO_EN gives requester 0 absolute priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_scheduler #(
  parameter int MEMORY_WIDTH = 4,
  parameter int NUM_REQ      = 4,
  parameter int REQ_IDX_SIZE = 2,
  parameter int BURST_LEN    = 3
) (
  input  wire logic            clk,
  input  wire logic            rst,
  fifo_wr_scheduler_if.master  bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [3:0]              c_last_beat = 4'(BURST_LEN - 1);
  localparam logic [REQ_IDX_SIZE-1:0] c_last_req  = REQ_IDX_SIZE'(NUM_REQ - 1);

`ifdef FIFO_SCHED_PRIO_EN
  // Requester 0 is handled by the override, so the rotation skips it.
  localparam int c_rr_first = 1;
`else
  localparam int c_rr_first = 0;
`endif

  state_t                  r_state;
  logic [3:0]              r_beat_cnt;
  logic [REQ_IDX_SIZE-1:0] r_owner;
  logic [REQ_IDX_SIZE-1:0] r_last_owner;
  logic                    r_busy;

  logic                    w_owner_req;
  logic [MEMORY_WIDTH-1:0] w_owner_data;
  logic                    w_beat;
  logic                    w_release;
  logic                    w_last_beat;
  logic [NUM_REQ-1:0]      w_gnt;
  logic [REQ_IDX_SIZE-1:0] w_pick;

  always_comb begin
    w_owner_req  = 1'b0;
    w_owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == REQ_IDX_SIZE'(i)) begin
        w_owner_req  = bus.req[i];
        w_owner_data = bus.req_data[i*MEMORY_WIDTH +: MEMORY_WIDTH];
      end
    end
  end

  assign w_beat      = (r_state == S_BURST) && w_owner_req && !bus.full;
  assign w_release   = (r_state == S_BURST) && !w_owner_req;
  assign w_last_beat = w_beat && (r_beat_cnt == c_last_beat);

  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt[i] = w_beat && (r_owner == REQ_IDX_SIZE'(i));
    end
  end

  // Scan distances from far to near so the nearest requester after
  // last_owner is the final (winning) assignment.
  always_comb begin
    w_pick = r_last_owner;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = c_rr_first; i < NUM_REQ; i++) begin
        if (bus.req[i] && (((int'(r_last_owner) + k) % NUM_REQ) == i)) begin
          w_pick = REQ_IDX_SIZE'(i);
        end
      end
    end
`ifdef FIFO_SCHED_PRIO_EN
    if (bus.req[0]) begin
      w_pick = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_beat_cnt   <= '0;
      r_owner      <= '0;
      r_last_owner <= c_last_req;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= S_BURST;
            r_busy     <= 1'b1;
          end
        end
        S_BURST: begin
          if (w_release || w_last_beat) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_last_owner <= r_owner;
            r_beat_cnt   <= '0;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = w_gnt;
  assign bus.w_en  = w_beat;
  assign bus.wdata = w_beat ? w_owner_data : '0;
  assign bus.owner = r_owner;
  assign bus.busy  = r_busy;

endmodule

`default_nettype wire
